// File: rtl/selector_funcion_pkg.sv
// rtl/selector_funcion_pkg.sv - shared state encoding and mode constants for the mode selector
package selector_funcion_pkg;

    typedef enum logic [3:0] {
        MODE_I   = 4'b0001,
        GAP_TO_F = 4'b0010,
        MODE_F   = 4'b0100,
        GAP_TO_I = 4'b1000
    } state_e;

    localparam logic MODE_INT  = 1'b0;
    localparam logic MODE_FUNC = 1'b1;

endpackage

// File: rtl/selector_funcion_sel_sync_debounce.sv
// rtl/selector_funcion_sel_sync_debounce.sv - synchroniser chain plus persistence filter for the raw select
module sel_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    output logic sel_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sel_db_q, sel_db_d;
    logic                   sel_s;

    assign sel_s  = sync_q[SYNC_STAGES-1];
    assign sel_db = sel_db_q;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sel};
        cnt_d    = '0;
        sel_db_d = sel_db_q;
        // Counter tracks how long sel_s has disagreed; any agreement restarts it.
        if (sel_s != sel_db_q) begin
            if (cnt_q == CNT_LAST) begin
                sel_db_d = sel_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            sel_db_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            sel_db_q <= sel_db_d;
        end
    end

endmodule

// File: rtl/selector_funcion.sv
// rtl/selector_funcion.sv - break-before-make mode FSM driving the integer/function path enables
module selector_funcion
    import selector_funcion_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel,
    output logic func,
    output logic ENf,
    output logic ENi
);

    logic   sel_db;
    state_e state_q, state_d;

    sel_sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_db (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel),
        .sel_db(sel_db)
    );

    always_comb begin
        state_d = MODE_I;
        unique case (state_q)
            MODE_I:   state_d = sel_db ? GAP_TO_F : MODE_I;
            GAP_TO_F: state_d = sel_db ? MODE_F   : MODE_I;
            MODE_F:   state_d = sel_db ? MODE_F   : GAP_TO_I;
            GAP_TO_I: state_d = sel_db ? MODE_F   : MODE_I;
            default:  state_d = MODE_I;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MODE_I;
        end else begin
            state_q <= state_d;
        end
    end

    // Pure decode of the state flops; an illegal encoding drives both enables low.
    always_comb begin
        func = MODE_INT;
        ENi  = 1'b0;
        ENf  = 1'b0;
        case (state_q)
            MODE_I:   ENi  = 1'b1;
            MODE_F: begin
                func = MODE_FUNC;
                ENf  = 1'b1;
            end
            GAP_TO_I: func = MODE_FUNC;
            default:  func = MODE_INT;
        endcase
    end

endmodule

// File: tb/tb_selector_funcion.sv
// tb/tb_selector_funcion.sv - directed self-checking bench for selector_funcion
module tb_selector_funcion;

    logic clk = 1'b0;
    logic rst_n;
    logic sel, sel2;
    logic func, ENf, ENi;
    logic func2, ENf2, ENi2;

    int checks   = 0;
    int failures = 0;

    // {func, ENi, ENf}
    localparam logic [2:0] ST_I  = 3'b010;
    localparam logic [2:0] ST_F  = 3'b101;
    localparam logic [2:0] ST_GF = 3'b000;
    localparam logic [2:0] ST_GI = 3'b100;

    always #5 clk = ~clk;

    selector_funcion #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel),
        .func (func),
        .ENf  (ENf),
        .ENi  (ENi)
    );

    selector_funcion #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_fast (
        .clk  (clk),
        .rst_n(rst_n),
        .sel  (sel2),
        .func (func2),
        .ENf  (ENf2),
        .ENi  (ENi2)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("no_overlap", {2'b00, ENf & ENi}, 3'b000);
        check("no_overlap_fast", {2'b00, ENf2 & ENi2}, 3'b000);
    endtask

    // sel changes just after an edge; edge 7 drops the old enable, edge 8 raises the new one.
    task automatic switch_to(input logic new_sel, input logic [2:0] old_st,
                             input logic [2:0] gap_st, input logic [2:0] new_st,
                             input string tag);
        sel = new_sel;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check({tag, "_hold"}, {func, ENi, ENf}, old_st);
        end
        tick();
        check({tag, "_gap"}, {func, ENi, ENf}, gap_st);
        tick();
        check({tag, "_new"}, {func, ENi, ENf}, new_st);
        for (int i = 0; i < 2; i++) begin
            tick();
            check({tag, "_steady"}, {func, ENi, ENf}, new_st);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 1'b0;
        sel2  = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset", {func, ENi, ENf}, ST_I);
            check("reset_fast", {func2, ENi2, ENf2}, ST_I);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_reset", {func, ENi, ENf}, ST_I);
        end

        switch_to(1'b1, ST_I, ST_GF, ST_F, "to_f");
        switch_to(1'b0, ST_F, ST_GI, ST_I, "to_i");
        switch_to(1'b1, ST_I, ST_GF, ST_F, "to_f2");
        switch_to(1'b0, ST_F, ST_GI, ST_I, "to_i2");

        // Three-cycle glitch is one short of the debounce window.
        sel = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sel = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch", {func, ENi, ENf}, ST_I);
        end

        // One-cycle pulse on the single-cycle-debounce instance enters GAP_TO_F then aborts.
        sel2 = 1'b1;
        tick();
        check("abort_e1", {func2, ENi2, ENf2}, ST_I);
        sel2 = 1'b0;
        tick();
        check("abort_e2", {func2, ENi2, ENf2}, ST_I);
        tick();
        check("abort_e3", {func2, ENi2, ENf2}, ST_I);
        tick();
        check("abort_gap", {func2, ENi2, ENf2}, ST_GF);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_back", {func2, ENi2, ENf2}, ST_I);
        end

        // Reset while in GAP_TO_F, then normal latency from the release.
        sel = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("mid_gap", {func, ENi, ENf}, ST_GF);
        rst_n = 1'b0;
        tick();
        check("mid_reset", {func, ENi, ENf}, ST_I);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("rel_hold", {func, ENi, ENf}, ST_I);
        end
        tick();
        check("rel_gap", {func, ENi, ENf}, ST_GF);
        tick();
        check("rel_f", {func, ENi, ENf}, ST_F);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rel_steady", {func, ENi, ENf}, ST_F);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/selector_funcion.md
Name: selector_funcion

Overview:
- Mode selector for the datapath: converts the single-bit user select `sel` (switch/pin, asynchronous to `clk`) into a clean registered mode flag `func` and two enables.
- `ENi` enables the integer path (mode I, sel=0). `ENf` enables the function path (mode F, sel=1).
- Input path: synchronise, then debounce.
- Mode changes are break-before-make: one cycle with both enables low. `ENf` and `ENi` are never high together.

Parameters:
- SYNC_STAGES, 2, number of flops in the `sel` synchroniser; legal range ≥2.
- DEBOUNCE_CYCLES, 4, consecutive cycles a new synchronised value must persist before acceptance; legal range ≥1, counter width = $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous reset, active low
- sel  input  1  raw mode select, asynchronous; 0 = mode I, 1 = mode F
- func  output  1  registered current mode, 0 = I, 1 = F
- ENf  output  1  function-path enable, high only in state MODE_F
- ENi  output  1  integer-path enable, high only in state MODE_I

Behaviour:
- Reset: rst_n sampled low at a rising edge does the following.
  - Synchroniser flops = 0; sel_db = 0; debounce counter = 0.
  - State = MODE_I, so outputs become func=0, ENi=1, ENf=0 after that edge.
  - Reset overrides everything, including mid-debounce and mid-gap.
- Synchroniser: SYNC_STAGES-flop shift chain. The last stage is sel_s.
- Debounce:
  - If sel_s == sel_db, the counter clears.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and sel_s still differs: sel_db <= sel_s and the counter clears.
  - Any pulse on sel_s shorter than DEBOUNCE_CYCLES cycles is ignored.
- FSM: one-hot states MODE_I, GAP_TO_F, MODE_F, GAP_TO_I. Transitions, evaluated each edge:
  - MODE_I: sel_db=1 -> GAP_TO_F, else stay.
  - GAP_TO_F: sel_db=1 -> MODE_F, else -> MODE_I (abort).
  - MODE_F: sel_db=0 -> GAP_TO_I, else stay.
  - GAP_TO_I: sel_db=0 -> MODE_I, else -> MODE_F (abort).
- Outputs: decoded directly from state flops, no combinational path from `sel`.
  - MODE_I: func=0, ENi=1, ENf=0.
  - MODE_F: func=1, ENi=0, ENf=1.
  - GAP_TO_F: func=0, ENi=0, ENf=0.
  - GAP_TO_I: func=1, ENi=0, ENf=0.
- Latency: `sel` stable before rising edge 0.
  - Old enable drops after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - New enable rises and func toggles after edge SYNC_STAGES+DEBOUNCE_CYCLES+2. Defaults: edge 7 and edge 8.
- Invariants:
  - ENf & ENi == 0 in every cycle.
  - func changes only on the same edge the new enable rises.
  - Exactly one state bit is set.
  - An illegal state encoding recovers to MODE_I on the next edge.
- Steady sel with no change: outputs hold indefinitely.

Decomposition:
- Shared package `selector_funcion_pkg`:
  - state enum: MODE_I, GAP_TO_F, MODE_F, GAP_TO_I, one-hot encoded.
  - localparams MODE_INT=1'b0, MODE_FUNC=1'b1.
- One sub-module `sel_sync_debounce`.
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, sel in; sel_db out.
  - Top holds the FSM and output decode.

Test Plan (10 ns clk, defaults):
- Reset: rst_n=0 for 3 edges with sel=0, release -> func=0, ENi=1, ENf=0 every cycle after the first reset edge.
- Switch to F: sel 0->1 held 100 ns -> ENi low after edge 7, ENf=1 and func=1 after edge 8; both enables low exactly one cycle.
- Toggle sequence: sel=1,0,1,0, each held 100 ns -> mode follows each step with 8-edge latency; ENf&ENi never 1; func matches ENf in non-gap cycles.
- Glitch: sel=1 for 3 cycles then back to 0 -> outputs unchanged (func=0, ENi=1) throughout.
- Abort in gap: force sel_db back to 0 during GAP_TO_F (via a pulse exactly DEBOUNCE_CYCLES long, then back) -> returns to MODE_I, ENf never asserts.
- Reset mid-operation: sel=1, assert rst_n=0 while in GAP_TO_F -> next edge func=0, ENi=1, ENf=0. With sel still 1 after release, MODE_F is reached 8 edges later.
